// File: rtl/codec_i2s_tx_pkg.sv
// Shared audio definitions for the filter chain and codec blocks.
// Holds sample/slot widths, channel indices and the channel-to-strobe-bit mapping.
package codec_i2s_tx_pkg;

    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned SLOT_W   = 32;
    localparam int unsigned NUM_CH   = 2;

    localparam int unsigned CH_L = 0;
    localparam int unsigned CH_R = 1;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Which din_valid bit carries the write strobe for a given channel.
    function automatic int unsigned ch_valid_bit(input int unsigned ch);
        return ch;
    endfunction

endpackage

// File: rtl/codec_i2s_tx_clk_gen.sv
// I2S master clock generator: divides clk into bclk, tracks the bit position
// within the stereo frame and derives lrclk plus slot-load strobes.
// Ports:
//   clk, rst          - system clock, async active-high reset
//   bclk, lrclk       - registered I2S bit clock / word select
//   bit_cnt           - bit position 0..2*SLOT_W-1, advances on bclk falls
//   bclk_fall_c       - high in the clk cycle whose edge takes bclk 1->0
//   slot_load_l_c/_r_c- high in the cycle where bit_cnt becomes 0 / SLOT_W
module codec_clk_gen #(
    parameter int unsigned BCLK_DIV = 16,
    parameter int unsigned SLOT_W   = codec_i2s_tx_pkg::SLOT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          bclk,
    output logic                          lrclk,
    output logic [$clog2(2*SLOT_W)-1:0]   bit_cnt,
    output logic                          bclk_fall_c,
    output logic                          slot_load_l_c,
    output logic                          slot_load_r_c
);
    import codec_i2s_tx_pkg::*;

    localparam int unsigned DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(2*SLOT_W);
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_DIV-1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(2*SLOT_W-1);
    localparam logic [CNT_W-1:0] CNT_R  = CNT_W'(SLOT_W);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    // Divider wrap toggles bclk; the 1->0 toggle advances the bit counter.
    always_comb begin
        div_d         = div_q;
        bclk_d        = bclk_q;
        lrclk_d       = lrclk_q;
        bit_cnt_d     = bit_cnt_q;
        bclk_fall_c   = 1'b0;
        slot_load_l_c = 1'b0;
        slot_load_r_c = 1'b0;
        if (div_q == DIV_TC) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
            if (bclk_q) begin
                bclk_fall_c   = 1'b1;
                bit_cnt_d     = (bit_cnt_q == CNT_TC) ? '0 : bit_cnt_q + 1'b1;
                lrclk_d       = (bit_cnt_d >= CNT_R);
                slot_load_l_c = (bit_cnt_d == '0);
                slot_load_r_c = (bit_cnt_d == CNT_R);
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            bit_cnt_q <= '0;
        end else begin
            div_q     <= div_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bclk    = bclk_q;
    assign lrclk   = lrclk_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/codec_i2s_tx.sv
// Stereo I2S master transmitter: buffers one sample per channel and
// serialises it MSB first with the standard one-bclk delay after lrclk.
// Ports:
//   clk, rst        - system clock, async active-high reset
//   din_valid, din  - per-channel sample write strobe and shared sample bus
//   frame_req       - pulse at each left-slot start (upstream pacing)
//   underrun        - per-channel pulse when a slot repeats a stale sample
//   overrun         - per-channel pulse when an unconsumed sample is overwritten
//   codec_bclk/lrclk/sdata - I2S interface to the DAC
module codec_i2s_tx #(
    parameter int unsigned BCLK_DIV = 16,
    parameter int unsigned SAMPLE_W = codec_i2s_tx_pkg::SAMPLE_W,
    parameter int unsigned SLOT_W   = codec_i2s_tx_pkg::SLOT_W
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [codec_i2s_tx_pkg::NUM_CH-1:0]  din_valid,
    input  logic [SAMPLE_W-1:0]                  din,
    output logic                                 frame_req,
    output logic [codec_i2s_tx_pkg::NUM_CH-1:0]  underrun,
    output logic [codec_i2s_tx_pkg::NUM_CH-1:0]  overrun,
    output logic                                 codec_bclk,
    output logic                                 codec_lrclk,
    output logic                                 codec_sdata
);
    import codec_i2s_tx_pkg::*;

    localparam int unsigned CNT_W = $clog2(2*SLOT_W);

    logic             bclk_fall, load_l, load_r;
    logic [CNT_W-1:0] bit_cnt, cnt_nxt, n_nxt;
    logic             ch_nxt;
    logic [NUM_CH-1:0] load;

    logic [NUM_CH-1:0][SAMPLE_W-1:0] hold_q, hold_d, shift_q, shift_d;
    logic [NUM_CH-1:0] fresh_q, fresh_d, armed_q, armed_d;
    logic [NUM_CH-1:0] underrun_q, underrun_d, overrun_q, overrun_d;
    logic              frame_req_q, frame_req_d;
    logic              sdata_q, sdata_d;

    codec_clk_gen #(
        .BCLK_DIV (BCLK_DIV),
        .SLOT_W   (SLOT_W)
    ) u_clk_gen (
        .clk           (clk),
        .rst           (rst),
        .bclk          (codec_bclk),
        .lrclk         (codec_lrclk),
        .bit_cnt       (bit_cnt),
        .bclk_fall_c   (bclk_fall),
        .slot_load_l_c (load_l),
        .slot_load_r_c (load_r)
    );

    // Bit position about to be entered on this bclk fall, and its slot/offset.
    assign cnt_nxt = (bit_cnt == CNT_W'(2*SLOT_W-1)) ? '0 : bit_cnt + 1'b1;
    assign ch_nxt  = (cnt_nxt >= CNT_W'(SLOT_W));
    assign n_nxt   = ch_nxt ? cnt_nxt - CNT_W'(SLOT_W) : cnt_nxt;

    always_comb begin
        load              = '0;
        load[1'(CH_L)]    = load_l;
        load[1'(CH_R)]    = load_r;
    end

    // Serialiser, slot loads and input buffering.
    always_comb begin
        hold_d      = hold_q;
        shift_d     = shift_q;
        fresh_d     = fresh_q;
        armed_d     = armed_q;
        underrun_d  = '0;
        overrun_d   = '0;
        frame_req_d = load_l;
        sdata_d     = sdata_q;

        if (bclk_fall) begin
            if (n_nxt != '0 && n_nxt <= CNT_W'(SAMPLE_W)) begin
                sdata_d          = shift_q[ch_nxt][SAMPLE_W-1];
                shift_d[ch_nxt]  = shift_q[ch_nxt] << 1;
            end else begin
                sdata_d = 1'b0;
            end
        end

        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            // Load consumes the old hold value; a same-cycle write refills for next frame.
            if (load[1'(ch)]) begin
                shift_d[1'(ch)]    = hold_q[1'(ch)];
                fresh_d[1'(ch)]    = 1'b0;
                underrun_d[1'(ch)] = armed_q[1'(ch)] & ~fresh_q[1'(ch)];
            end
            if (din_valid[1'(ch_valid_bit(ch))]) begin
                hold_d[1'(ch)]    = din;
                overrun_d[1'(ch)] = fresh_q[1'(ch)] & ~load[1'(ch)];
                fresh_d[1'(ch)]   = 1'b1;
                armed_d[1'(ch)]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            shift_q     <= '0;
            fresh_q     <= '0;
            armed_q     <= '0;
            underrun_q  <= '0;
            overrun_q   <= '0;
            frame_req_q <= 1'b0;
            sdata_q     <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            fresh_q     <= fresh_d;
            armed_q     <= armed_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
            frame_req_q <= frame_req_d;
            sdata_q     <= sdata_d;
        end
    end

    assign frame_req   = frame_req_q;
    assign underrun    = underrun_q;
    assign overrun     = overrun_q;
    assign codec_sdata = sdata_q;

endmodule

// File: tb/tb_codec_i2s_tx.sv
// Self-checking bench for codec_i2s_tx: a frame-level reference model derived
// from elapsed clk cycles, an I2S receiver decoding sdata, and literal checks.
module tb_codec_i2s_tx;
    localparam int unsigned DIV  = 2;
    localparam int unsigned SW   = 24;
    localparam int unsigned SLOT = 32;
    localparam int unsigned BITP = 2*DIV;

    logic        clk, rst;
    logic [1:0]  din_valid;
    logic [23:0] din;
    logic        frame_req, codec_bclk, codec_lrclk, codec_sdata;
    logic [1:0]  underrun, overrun;

    int checks = 0;
    int errors = 0;

    codec_i2s_tx #(.BCLK_DIV(DIV), .SAMPLE_W(SW), .SLOT_W(SLOT)) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .frame_req   (frame_req),
        .underrun    (underrun),
        .overrun     (overrun),
        .codec_bclk  (codec_bclk),
        .codec_lrclk (codec_lrclk),
        .codec_sdata (codec_sdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: k = clk edges since reset release.
    int          k;
    logic [23:0] m_hold [2];
    logic [23:0] m_cur  [2];
    logic [1:0]  m_fresh, m_armed;
    logic [7:0]  exp_vec;

    // Receiver / monitor state.
    logic        prev_b, prev_lr;
    int          pos, first_rise;
    logic [23:0] sh;
    logic [23:0] dec [2];
    int          fr_cnt;
    int          ur_cnt [2];
    int          ov_cnt [2];

    task automatic step_model();
        int ch, bi, n, lr;
        logic [1:0] ur, ov;
        logic fr, eb, esd;
        if (rst) begin
            k = 0;
            m_hold[0] = '0; m_hold[1] = '0;
            m_cur[0]  = '0; m_cur[1]  = '0;
            m_fresh = '0; m_armed = '0;
            exp_vec = '0;
        end else begin
            k++;
            ur = '0; ov = '0; fr = 1'b0;
            if (k % BITP == 0 && (k / BITP) % SLOT == 0) begin
                ch = (k / BITP / SLOT) % 2;
                m_cur[ch] = m_hold[ch];
                ur[ch] = m_armed[ch] && !m_fresh[ch];
                m_fresh[ch] = 1'b0;
                if (ch == 0) fr = 1'b1;
            end
            for (int c = 0; c < 2; c++) begin
                if (din_valid[c]) begin
                    ov[c] = m_fresh[c];
                    m_hold[c] = din;
                    m_fresh[c] = 1'b1;
                    m_armed[c] = 1'b1;
                end
            end
            bi  = (k / BITP) % (2*SLOT);
            n   = bi % SLOT;
            lr  = (bi >= SLOT) ? 1 : 0;
            eb  = ((k / DIV) % 2) == 1;
            esd = (n >= 1 && n <= SW) ? m_cur[lr][SW-n] : 1'b0;
            exp_vec = {eb, lr[0], esd, fr, ur, ov};
        end
    endtask

    task automatic tick();
        logic [7:0] got;
        @(negedge clk);
        step_model();
        got = {codec_bclk, codec_lrclk, codec_sdata, frame_req, underrun, overrun};
        checks++;
        if (got !== exp_vec) begin
            errors++;
            $display("FAIL cycle_compare k=%0d {bclk,lrclk,sdata,fr,ur[1:0],ov[1:0]} got=%b exp=%b",
                     k, got, exp_vec);
        end
        if (rst) begin
            prev_b = 1'b0; prev_lr = 1'b0; pos = 0; sh = '0; first_rise = -1;
        end else begin
            fr_cnt += int'(frame_req);
            for (int c = 0; c < 2; c++) begin
                ur_cnt[c] += int'(underrun[c]);
                ov_cnt[c] += int'(overrun[c]);
            end
            if (codec_bclk && !prev_b) begin
                if (first_rise < 0) first_rise = k;
                if (codec_lrclk != prev_lr) pos = 0;
                if (pos >= 1 && pos <= SW) sh = {sh[SW-2:0], codec_sdata};
                if (pos == SW) dec[codec_lrclk] = sh;
                pos++;
                prev_lr = codec_lrclk;
            end
            prev_b = codec_bclk;
        end
        din = 24'($urandom);
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic write(input logic [1:0] v, input logic [23:0] d);
        din_valid = v;
        din = d;
        tick();
        din_valid = 2'b00;
    endtask

    task automatic wait_fr();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            tick();
            if (frame_req) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_frame_req timeout got=none exp=pulse within 600 cycles");
        end
    endtask

    task automatic clear_cnts();
        fr_cnt = 0;
        for (int c = 0; c < 2; c++) begin
            ur_cnt[c] = 0;
            ov_cnt[c] = 0;
        end
    endtask

    initial begin
        rst = 1'b1;
        din_valid = 2'b00;
        din = '0;
        dec[0] = '0; dec[1] = '0;
        clear_cnts();
        idle(3);
        lit("reset_outputs", 32'({codec_bclk, codec_lrclk, codec_sdata, frame_req, underrun, overrun}), 0);
        rst = 1'b0;
        clear_cnts();

        // Idle three frames.
        idle(800);
        lit("idle_frame_req_count", fr_cnt, 3);
        lit("idle_underrun_count", ur_cnt[0] + ur_cnt[1], 0);
        lit("first_bclk_rise_cycle", first_rise, DIV);
        lit("idle_left_decoded", dec[0], 0);

        // Single left write, then starve for two frames.
        wait_fr(); idle(4);
        clear_cnts();
        write(2'b01, 24'h123456);
        wait_fr(); idle(120);
        lit("stale_left_frame1", dec[0], 24'h123456);
        wait_fr(); idle(120);
        wait_fr(); idle(120);
        lit("stale_left_frame3", dec[0], 24'h123456);
        lit("stale_right_zero", dec[1], 0);
        lit("stale_underrun_left", ur_cnt[0], 2);
        lit("stale_underrun_right", ur_cnt[1], 0);

        // Full-scale extremes on both channels.
        wait_fr(); idle(4);
        write(2'b01, 24'h800001);
        write(2'b10, 24'h7FFFFF);
        wait_fr(); idle(120);
        lit("extreme_left", dec[0], 24'h800001);
        lit("extreme_right", dec[1], 24'h7FFFFF);

        // Two left writes inside one frame: latest wins.
        wait_fr(); idle(4);
        clear_cnts();
        write(2'b01, 24'h000AAA);
        idle(10);
        write(2'b01, 24'h000BBB);
        idle(4);
        lit("overrun_left_count", ov_cnt[0], 1);
        lit("overrun_right_count", ov_cnt[1], 0);
        wait_fr(); idle(120);
        lit("overrun_latest_wins", dec[0], 24'h000BBB);

        // Both strobes at once share din.
        wait_fr(); idle(4);
        clear_cnts();
        write(2'b11, 24'h00F00F);
        wait_fr(); idle(120);
        lit("dual_write_left", dec[0], 24'h00F00F);
        lit("dual_write_right", dec[1], 24'h00F00F);
        lit("dual_write_no_overrun", ov_cnt[0] + ov_cnt[1], 0);

        // Random write traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 6*256; i++) begin
            if ($urandom_range(0, 40) == 0) din_valid = 2'($urandom_range(1, 3));
            else                            din_valid = 2'b00;
            din = 24'($urandom);
            tick();
        end
        din_valid = 2'b00;

        // Reset in the middle of a right slot.
        wait_fr(); idle(150);
        rst = 1'b1;
        #1;
        lit("midframe_reset_outputs", 32'({codec_bclk, codec_lrclk, codec_sdata, frame_req, underrun, overrun}), 0);
        idle(3);
        rst = 1'b0;
        clear_cnts();
        idle(600);
        lit("post_reset_frame_req_count", fr_cnt, 2);
        lit("post_reset_underrun", ur_cnt[0] + ur_cnt[1], 0);
        lit("post_reset_first_rise", first_rise, DIV);
        lit("post_reset_left_zero", dec[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
